// File: rtl/cpu0_mem_pkg.sv
// cpu0_mem_pkg: shared types and helpers for the CPU0 memory controller.
// FSM state encoding, access direction/size constants and byte-lane helpers
// (big-endian: lane offset 0 is bits [31:24], offset 3 is bits [7:0]).
package cpu0_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;
    localparam logic SZ_BYTE  = 1'b1;
    localparam logic SZ_WORD  = 1'b0;

    // Byte write enables for an access: all four lanes for a word, one
    // big-endian lane for a byte (we[3] covers bits [31:24]).
    function automatic logic [3:0] lane_we(input logic w1, input logic [1:0] off);
        logic [3:0] we;
        if (w1 == SZ_WORD) begin
            we = 4'b1111;
        end else begin
            we = 4'b1000 >> off;
        end
        return we;
    endfunction

    // Extract the big-endian byte selected by off from a 32-bit word.
    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] off);
        logic [7:0] b;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/cpu0_mem_array.sv
// cpu0_mem_array: synchronous single-port word storage with per-byte write
// enables and a registered read port. Contents are never reset.
module cpu0_mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] addr_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Per-lane write and read-before-write registered read on enabled cycles.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cpu0_mem_ctrl.sv
// cpu0_mem_ctrl: CPU0 memory controller. Latches one CPU request in IDLE,
// optionally waits WAIT_STATES cycles, performs the storage access, then
// pulses m_ready (with m_err) for one cycle. Read data stays on dbus until the
// next read completes.
// Optional build macro CPU0_MEM_CHK_EN: flags misaligned word accesses and
// out-of-range addresses as errors (no write, read data 0, m_err pulsed).
// Without it, m_err is 0, word accesses ignore mar[1:0] and addresses wrap.
module cpu0_mem_ctrl
    import cpu0_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m_en,
    input  logic              m_rw,
    input  logic              m_w1,
    input  logic [ADDR_W-1:0] mar,
    input  logic [31:0]       mdr,
    output logic [31:0]       dbus,
    output logic              m_ready,
    output logic              m_err
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS_LAST = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    state_e             state_q;
    logic [3:0]         wcnt_q;
    logic [IDX_W+1:0]   addr_q;
    logic [31:0]        mdr_q;
    logic               rw_q;
    logic               w1_q;
    logic               err_q;
    logic [31:0]        dbus_q;
    logic               m_ready_q;
    logic               m_err_q;

    logic               err_d;
    logic               arr_en;
    logic [3:0]         arr_we;
    logic [IDX_W-1:0]   arr_addr;
    logic [31:0]        arr_wdata;
    logic [31:0]        arr_rdata;
    logic [31:0]        rdata_d;

`ifdef CPU0_MEM_CHK_EN
    // Classify the incoming request; the verdict is latched with it.
    always_comb begin
        err_d = 1'b0;
        if ((m_w1 == SZ_WORD) && (mar[1:0] != 2'b00)) begin
            err_d = 1'b1;
        end
        if (64'(mar) >= (64'(DEPTH_WORDS) * 64'd4)) begin
            err_d = 1'b1;
        end
    end
`else
    assign err_d = 1'b0;
    logic unused_mar_hi;
    assign unused_mar_hi = ^mar[ADDR_W-1:IDX_W+2];
`endif

    // Storage is only touched in ACCESS; errored requests never write.
    always_comb begin
        arr_en = (state_q == ST_ACCESS);
        arr_we = '0;
        if ((state_q == ST_ACCESS) && (rw_q == RW_WRITE) && !err_q) begin
            arr_we = lane_we(w1_q, addr_q[1:0]);
        end
    end

    assign arr_addr  = addr_q[IDX_W+1:2];
    assign arr_wdata = (w1_q == SZ_BYTE) ? {4{mdr_q[7:0]}} : mdr_q;

    // Format read data: zero for errors, zero-extended lane for byte reads.
    always_comb begin
        rdata_d = arr_rdata;
        if (err_q) begin
            rdata_d = '0;
        end else if (w1_q == SZ_BYTE) begin
            rdata_d = {24'd0, lane_byte(arr_rdata, addr_q[1:0])};
        end
    end

    cpu0_mem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i  (clk),
        .en_i   (arr_en),
        .we_i   (arr_we),
        .addr_i (arr_addr),
        .wdata_i(arr_wdata),
        .rdata_o(arr_rdata)
    );

    // Request FSM with registered completion outputs; reset aborts any
    // request before its ACCESS edge, so an uncommitted write never lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            addr_q    <= '0;
            mdr_q     <= '0;
            rw_q      <= RW_READ;
            w1_q      <= SZ_WORD;
            err_q     <= 1'b0;
            dbus_q    <= '0;
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
        end else begin
            m_ready_q <= 1'b0;
            m_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (m_en) begin
                        addr_q  <= mar[IDX_W+1:0];
                        mdr_q   <= mdr;
                        rw_q    <= m_rw;
                        w1_q    <= m_w1;
                        err_q   <= err_d;
                        wcnt_q  <= '0;
                        state_q <= (WAIT_STATES > 0) ? ST_WAIT : ST_ACCESS;
                    end
                end
                ST_WAIT: begin
                    if (wcnt_q == WS_LAST) begin
                        wcnt_q  <= '0;
                        state_q <= ST_ACCESS;
                    end else begin
                        wcnt_q <= wcnt_q + 4'd1;
                    end
                end
                ST_ACCESS: begin
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    m_ready_q <= 1'b1;
                    m_err_q   <= err_q;
                    if (rw_q == RW_READ) begin
                        dbus_q <= rdata_d;
                    end
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbus    = dbus_q;
    assign m_ready = m_ready_q;
    assign m_err   = m_err_q;

endmodule

// File: tb/tb_cpu0_mem_ctrl.sv
// tb_cpu0_mem_ctrl: two controllers (WAIT_STATES 0 and 3) driven with directed
// requests; a reference model predicts completion cycle, dbus and m_err, and
// one compare process checks every cycle. Literal checks pin key results.
module tb_cpu0_mem_ctrl;

    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        m_en    [2];
    logic        m_rw    [2];
    logic        m_w1    [2];
    logic [31:0] mar     [2];
    logic [31:0] mdr     [2];
    logic [31:0] dbus    [2];
    logic        m_ready [2];
    logic        m_err   [2];

    cpu0_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0), .ADDR_W(32)) u_dut0 (
        .clk(clk), .rst(rst), .m_en(m_en[0]), .m_rw(m_rw[0]), .m_w1(m_w1[0]),
        .mar(mar[0]), .mdr(mdr[0]), .dbus(dbus[0]), .m_ready(m_ready[0]), .m_err(m_err[0])
    );

    cpu0_mem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3), .ADDR_W(32)) u_dut1 (
        .clk(clk), .rst(rst), .m_en(m_en[1]), .m_rw(m_rw[1]), .m_w1(m_w1[1]),
        .mar(mar[1]), .mdr(mdr[1]), .dbus(dbus[1]), .m_ready(m_ready[1]), .m_err(m_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state
    logic [31:0] mm       [2][DEPTH];
    int          cyc;
    int          exp_cyc  [2];
    int          exp_acc  [2];
    logic [31:0] exp_dbus [2];
    logic        exp_err  [2];
    logic [31:0] cur_dbus [2];
    logic [31:0] last_rd  [2];
    logic        last_err [2];
    int          lat      [2];
    int          n_cmp;
    int          n_fail;

    function automatic int ws(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model of one request: predicts completion and result, updates storage.
    task automatic model_req(input int d, input logic rd, input logic byte_acc,
                             input logic [31:0] a, input logic [31:0] wd);
        int unsigned idx;
        int unsigned sh;
        logic        err;
        idx = (a / 4) % DEPTH;
        sh  = 8 * (3 - (a % 4));
        err = 1'b0;
`ifdef CPU0_MEM_CHK_EN
        err = ((!byte_acc) && ((a % 4) != 0)) || (a >= 4 * DEPTH);
`endif
        exp_err[d] = err;
        if (rd) begin
            if (err)           exp_dbus[d] = 32'd0;
            else if (byte_acc) exp_dbus[d] = (mm[d][idx] >> sh) & 32'hFF;
            else               exp_dbus[d] = mm[d][idx];
        end else begin
            exp_dbus[d] = cur_dbus[d];
            if (!err) begin
                if (byte_acc) mm[d][idx] = (mm[d][idx] & ~(32'hFF << sh)) | ({24'd0, wd[7:0]} << sh);
                else          mm[d][idx] = wd;
            end
        end
        exp_acc[d] = cyc + 1;
        exp_cyc[d] = cyc + 1 + ws(d) + 2;
    endtask

    // Called at a negedge; returns at the negedge of the completion cycle.
    task automatic issue(input int d, input logic rd, input logic byte_acc,
                         input logic [31:0] a, input logic [31:0] wd);
        m_en[d] = 1'b1;
        m_rw[d] = rd;
        m_w1[d] = byte_acc;
        mar[d]  = a;
        mdr[d]  = wd;
        model_req(d, rd, byte_acc, a, wd);
        @(negedge clk);
        m_en[d] = 1'b0;
        mar[d]  = $urandom;
        mdr[d]  = $urandom;
        m_rw[d] = ~rd;
        m_w1[d] = ~byte_acc;
        while (cyc < exp_cyc[d]) @(negedge clk);
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after posedge.
    initial begin
        logic er;
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            exp_cyc[d]  = -1;
            exp_acc[d]  = 0;
            cur_dbus[d] = '0;
            exp_dbus[d] = '0;
            exp_err[d]  = 1'b0;
        end
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            for (int d = 0; d < 2; d++) begin
                er = rst && (cyc == exp_cyc[d]);
                if (er) begin
                    cur_dbus[d] = exp_dbus[d];
                    lat[d]      = cyc - exp_acc[d];
                    last_rd[d]  = dbus[d];
                    last_err[d] = m_err[d];
                end
                check($sformatf("dut%0d m_ready c%0d", d, cyc), {31'd0, m_ready[d]}, {31'd0, er});
                check($sformatf("dut%0d m_err c%0d", d, cyc), {31'd0, m_err[d]}, {31'd0, er && exp_err[d]});
                check($sformatf("dut%0d dbus c%0d", d, cyc), dbus[d], cur_dbus[d]);
            end
        end
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b0;
        for (int d = 0; d < 2; d++) begin
            m_en[d] = 1'b0; m_rw[d] = 1'b1; m_w1[d] = 1'b0; mar[d] = '0; mdr[d] = '0;
            lat[d] = 0; last_rd[d] = '0; last_err[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("reset dbus0", dbus[0], 32'h0);
        check("reset m_ready1", {31'd0, m_ready[1]}, 32'h0);
        rst = 1'b1;
        @(negedge clk);

        // Word write/read, zero wait states
        issue(0, 1'b0, 1'b0, 32'h10, 32'h12345678);
        check("lat wr ws0", 32'(lat[0]), 32'd2);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0);
        check("rd 0x10", last_rd[0], 32'h12345678);
        check("lat rd ws0", 32'(lat[0]), 32'd2);

        // Byte lane write then word and byte reads
        issue(0, 1'b0, 1'b1, 32'h11, 32'hFFFFFFAB);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0);
        check("rd 0x10 after byte wr", last_rd[0], 32'h12AB5678);
        issue(0, 1'b1, 1'b1, 32'h13, 32'h0);
        check("byte rd 0x13", last_rd[0], 32'h00000078);

        // Fill 0x40 lane by lane
        issue(0, 1'b0, 1'b0, 32'h40, 32'h0);
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b0, 1'b1, 32'h40 + 32'(i), 32'h11 * 32'(i + 1));
        end
        issue(0, 1'b1, 1'b0, 32'h40, 32'h0);
        check("rd 0x40 lanes", last_rd[0], 32'h11223344);
        for (int i = 0; i < 4; i++) begin
            issue(0, 1'b1, 1'b1, 32'h40 + 32'(i), 32'h0);
        end
        check("byte rd 0x43", last_rd[0], 32'h00000044);

`ifdef CPU0_MEM_CHK_EN
        issue(0, 1'b0, 1'b0, 32'h12, 32'hDEADBEEF);
        check("misaligned wr err", {31'd0, last_err[0]}, 32'd1);
        issue(0, 1'b1, 1'b0, 32'h10, 32'h0);
        check("0x10 unchanged", last_rd[0], 32'h12AB5678);
        issue(0, 1'b1, 1'b0, 32'(4 * DEPTH), 32'h0);
        check("oor rd err", {31'd0, last_err[0]}, 32'd1);
        check("oor rd dbus", last_rd[0], 32'h0);
`else
        issue(0, 1'b0, 1'b0, 32'h1000, 32'hCAFEF00D);
        issue(0, 1'b1, 1'b0, 32'h0, 32'h0);
        check("alias 0x1000", last_rd[0], 32'hCAFEF00D);
        issue(0, 1'b1, 1'b0, 32'h13, 32'h0);
        check("misaligned word rd", last_rd[0], 32'h12AB5678);
        check("no err default", {31'd0, last_err[0]}, 32'd0);
`endif

        // Three wait states
        issue(1, 1'b0, 1'b0, 32'h20, 32'h0BADF00D);
        check("lat wr ws3", 32'(lat[1]), 32'd5);
        issue(1, 1'b1, 1'b0, 32'h20, 32'h0);
        check("rd 0x20 ws3", last_rd[1], 32'h0BADF00D);
        check("lat rd ws3", 32'(lat[1]), 32'd5);
        issue(1, 1'b0, 1'b1, 32'h2E, 32'h0000005A);
        issue(1, 1'b1, 1'b0, 32'h2C, 32'h0);
        issue(1, 1'b1, 1'b1, 32'h2E, 32'h0);
        check("byte rd 0x2E", last_rd[1], 32'h0000005A);

        // Reset during WAIT of a write to 0x20 aborts it
        m_en[1] = 1'b1; m_rw[1] = 1'b0; m_w1[1] = 1'b0; mar[1] = 32'h20; mdr[1] = 32'hDEADBEEF;
        @(negedge clk);
        m_en[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_cyc[d]  = -1;
            cur_dbus[d] = '0;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        issue(1, 1'b1, 1'b0, 32'h20, 32'h0);
        check("0x20 after abort", last_rd[1], 32'h0BADF00D);
        check("lat after reset", 32'(lat[1]), 32'd5);
        issue(0, 1'b1, 1'b0, 32'h40, 32'h0);
        check("storage kept", last_rd[0], 32'h11223344);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu0_mem_ctrl.md
CPU0_MEM_CTRL -- requirements
Module: cpu0_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the storage depth in 32-bit words (power of two, 16..65536).
REQ-002 The block SHALL have parameter WAIT_STATES, default 0, meaning the extra cycles inserted before each access (0..15).
REQ-003 The block SHALL have parameter ADDR_W, default 32, meaning the CPU byte-address width.
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port m_en, input, 1, meaning CPU request valid.
REQ-007 The block SHALL have port m_rw, input, 1, meaning 1=read, 0=write.
REQ-008 The block SHALL have port m_w1, input, 1, meaning 1=byte access, 0=word access.
REQ-009 The block SHALL have port mar, input, ADDR_W, meaning the byte address.
REQ-010 The block SHALL have port mdr, input, 32, meaning the write data (a byte write uses mdr[7:0]).
REQ-011 The block SHALL have port dbus, output, 32, meaning the read data.
REQ-012 The block SHALL have port m_ready, output, 1, meaning a one-cycle completion pulse.
REQ-013 The block SHALL have port m_err, output, 1, meaning access error, valid only with m_ready.

Function
REQ-014 The FSM SHALL have the states IDLE, WAIT, ACCESS and DONE.
REQ-015 In IDLE with m_en=1, the block SHALL latch mar, mdr, m_rw and m_w1, then go to WAIT if WAIT_STATES>0, else to ACCESS.
REQ-016 WAIT SHALL count WAIT_STATES cycles, then go to ACCESS.
REQ-017 ACCESS SHALL perform the storage read or write, then go to DONE.
REQ-018 DONE SHALL assert m_ready (and m_err if applicable) for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be m_ready high WAIT_STATES+2 cycles after the accepting edge.
REQ-020 Back-to-back requests SHALL be possible: m_en is re-sampled in the IDLE cycle that follows DONE, so there is at most one request per WAIT_STATES+3 cycles.
REQ-021 Once a request is accepted, deasserting m_en SHALL NOT abort it, and changes on mar/mdr SHALL be ignored until IDLE.
REQ-022 Read data SHALL appear on dbus in the DONE cycle and hold until the next read completes; writes SHALL NOT change dbus.
REQ-023 Word index SHALL be mar[log2(DEPTH_WORDS)+1:2].
REQ-024 Byte lane SHALL be selected by mar[1:0], big-endian: 0 selects bits [31:24], 3 selects bits [7:0].
REQ-025 A byte read SHALL return the selected byte zero-extended in dbus[7:0].
REQ-026 A byte write SHALL modify only the selected lane.
REQ-027 A word access SHALL use all four lanes.

Reset
REQ-028 While rst=0, the FSM SHALL be IDLE, the wait counter 0, m_ready=0, m_err=0 and dbus=0.
REQ-029 Reset asserted during WAIT or ACCESS SHALL abort the request, and a write not yet committed at the ACCESS edge SHALL NOT occur.
REQ-030 Storage contents SHALL NOT be reset.

Configuration
REQ-031 With CPU0_MEM_CHK_EN defined, a word access with mar[1:0]!=0 SHALL be flagged as an error.
REQ-032 With CPU0_MEM_CHK_EN defined, an access with mar >= 4*DEPTH_WORDS SHALL be flagged as an error.
REQ-033 With CPU0_MEM_CHK_EN defined, an errored access SHALL perform no write, return dbus=0 on reads, and pulse m_err with m_ready.
REQ-034 Without CPU0_MEM_CHK_EN, m_err SHALL be tied to 0, a misaligned word access SHALL ignore mar[1:0], and addresses SHALL wrap modulo DEPTH_WORDS.

Structure
REQ-035 Package cpu0_mem_pkg SHALL hold the FSM state enum, the RW_READ/RW_WRITE and SZ_BYTE/SZ_WORD constants, and the lane-select function.
REQ-036 The storage SHALL be a sub-module cpu0_mem_array: synchronous, single-port, DEPTH_WORDS x 32, with a 4-bit byte write enable and registered read.

Verification
REQ-037 With WAIT_STATES=0, a word write of 0x12345678 to 0x10 followed by a word read of 0x10 SHALL return dbus=0x12345678 with m_ready 2 cycles after acceptance.
REQ-038 A byte write of 0xAB to 0x11 over word 0x12345678, then a word read of 0x10, SHALL return 0x12AB5678; a byte read of 0x13 SHALL return 0x00000078.
REQ-039 With WAIT_STATES=3, m_ready SHALL pulse exactly 5 cycles after acceptance, and m_en dropped after acceptance SHALL still complete the access.
REQ-040 With CPU0_MEM_CHK_EN, a word write to 0x12 SHALL give m_err=1 and leave memory unchanged; a read of 4*DEPTH_WORDS SHALL give m_err=1 and dbus=0.
REQ-041 Without CPU0_MEM_CHK_EN and DEPTH_WORDS=1024, a write to 0x1000 SHALL alias address 0x0.
REQ-042 rst pulsed low during WAIT of a write to 0x20 SHALL leave address 0x20 unchanged and return the FSM to IDLE with m_ready=0.
